kuznechik_arbiter: RTL and testbench
====================================

KUZNECHIK_ARBITER -- requirements
Module: kuznechik_arbiter

Interface
REQ-001 Parameter N_REQ, default 2: number of requester channels (2..4).
REQ-002 Parameter TIMEOUT, default 255: maximum core cycles to wait for a result, range 1..255.
REQ-003 clk_i  in  1  single clock, all state on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 req_valid_i  in  N_REQ  requester i presents a 128-bit block.
REQ-006 req_data_i  in  128*N_REQ  block of requester i at bits [128*i+127:128*i].
REQ-007 req_ready_o  out  N_REQ  block of requester i accepted this cycle.
REQ-008 rsp_valid_o  out  N_REQ  result for requester i is available.
REQ-009 rsp_data_o  out  128  result data, shared by all channels.
REQ-010 rsp_ready_i  in  N_REQ  requester i consumes its result.
REQ-011 err_o  out  N_REQ  one-cycle pulse, timeout on requester i's job.
REQ-012 busy_o  out  1  arbiter not in IDLE.
REQ-013 core_request_o  out  1  start pulse to cipher core.
REQ-014 core_data_o  out  128  plaintext to cipher core.
REQ-015 core_ack_o  out  1  result-consumed pulse to cipher core.
REQ-016 core_busy_i  in  1  cipher core busy; monitored only.
REQ-017 core_valid_i  in  1  cipher core result valid.
REQ-018 core_data_i  in  128  cipher core result.

Function
REQ-019 States: IDLE, ISSUE, WAIT, RESP, ACK; one-hot or binary encoding is free.
REQ-020 IDLE: if any req_valid_i is set, grant the lowest index at or after rr_ptr (wrapping), assert req_ready_o[g] combinationally that cycle, register req_data_i[g] into core_data_o, store g, go to ISSUE.
REQ-021 req_ready_o SHALL be one-hot or zero, and nonzero only in IDLE.
REQ-022 ISSUE: core_request_o=1 for exactly this one cycle; clear the timeout counter; go to WAIT.
REQ-023 WAIT: the 8-bit counter increments each cycle; on core_valid_i=1, register core_data_i into rsp_data_o and go to RESP.
REQ-024 WAIT timeout: when the counter equals TIMEOUT with core_valid_i=0, pulse err_o[g] for one cycle and go to ACK without asserting rsp_valid_o.
REQ-025 If core_valid_i=1 arrives in the same cycle as the timeout, the valid takes priority (no error).
REQ-026 RESP: hold rsp_valid_o[g]=1 and rsp_data_o stable until rsp_ready_i[g]=1; on that handshake go to ACK.
REQ-027 ACK: core_ack_o=1 for one cycle; rr_ptr <= (g+1) mod N_REQ; go to IDLE.
REQ-028 Minimum accept-to-next-accept spacing is core latency + 4 cycles; a requester waits at most N_REQ-1 other jobs.
REQ-029 Ignore core_valid_i outside WAIT, rsp_ready_i outside RESP, and rsp_ready_i[j] for j != g.
REQ-030 Requesters hold req_valid_i and req_data_i until req_ready_o; withdrawing before that cancels the request with no side effects.
REQ-031 busy_o = (state != IDLE), combinational.

Reset
REQ-032 rst_i=1 SHALL immediately force state IDLE, rr_ptr=0, counter=0, core_data_o=0, rsp_data_o=0, and every output 0, regardless of state.
REQ-033 Reset mid-job SHALL abandon the job with no err_o or core_ack_o pulse; the first accept after release follows REQ-020 with rr_ptr=0.

Verification
REQ-034 Single job: req_valid_i[0]=1, data 1122334455667700ffeeddccbbaa9988, core model returns 7f679d90bebc24305a468d42b9d4edcd after 40 cycles -> req_ready_o[0] pulses once; core_request_o pulses 1 cycle later; rsp_valid_o[0] with that ciphertext; core_ack_o pulses after rsp_ready_i[0].
REQ-035 Contention: req_valid_i=2'b11 held continuously -> grants alternate 0,1,0,1 over 4 jobs; never two ready bits set at once.
REQ-036 Backpressure: rsp_ready_i[1]=0 for 20 cycles -> rsp_valid_o[1] and rsp_data_o stable throughout; no new accept until the handshake and ACK complete.
REQ-037 Timeout: core never asserts valid, TIMEOUT=10 -> err_o[g] pulses exactly once, 11 cycles after core_request_o; rsp_valid_o stays 0; core_ack_o pulses next cycle; returns to IDLE.
REQ-038 Reset in WAIT: assert rst_i 5 cycles after core_request_o -> all outputs 0 in the same cycle; after release, req_valid_i=2'b11 -> requester 0 is granted first.
REQ-039 Race: core_valid_i coincides with the timeout cycle -> result delivered, err_o stays 0.

Source files
------------

// File: rtl/kuznechik_arbiter.sv
// kuznechik_arbiter
// Round-robin front end that shares one Kuznechik cipher core between
// N_REQ requesters. One job is in flight at a time. A job runs
// IDLE -> ISSUE -> WAIT -> RESP -> ACK. A job that times out skips RESP.
//
// Ports
//   clk_i, rst_i     clock; asynchronous active-high reset
//   req_valid_i      per-requester block valid (held until req_ready_o)
//   req_data_i       per-requester 128-bit block, channel i at [128*i +: 128]
//   req_ready_o      one-hot accept strobe, only ever asserted in IDLE
//   rsp_valid_o      per-requester result valid, held until rsp_ready_i[g]
//   rsp_data_o       shared 128-bit result register
//   rsp_ready_i      per-requester result consume
//   err_o            one-cycle timeout pulse for the granted requester
//   busy_o           arbiter not idle
//   core_request_o   one-cycle start pulse to the core
//   core_data_o      registered plaintext to the core
//   core_ack_o       one-cycle result-consumed pulse to the core
//   core_busy_i      core busy, monitored only
//   core_valid_i     core result valid, sampled only in WAIT
//   core_data_i      core result
module kuznechik_arbiter #(
  parameter int N_REQ   = 2,   // 2..4
  parameter int TIMEOUT = 255  // 1..255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [128*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic [N_REQ-1:0]     rsp_valid_o,
  output logic [127:0]         rsp_data_o,
  input  logic [N_REQ-1:0]     rsp_ready_i,
  output logic [N_REQ-1:0]     err_o,
  output logic                 busy_o,
  output logic                 core_request_o,
  output logic [127:0]         core_data_o,
  output logic                 core_ack_o,
  input  logic                 core_busy_i,
  input  logic                 core_valid_i,
  input  logic [127:0]         core_data_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_ACK
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t       r_state;
  state_t       w_next;
  logic [1:0]   r_grant;
  logic [1:0]   r_rr_ptr;
  logic [7:0]   r_cnt;
  logic [127:0] r_core_data;
  logic [127:0] r_rsp_data;

  logic         w_found;
  logic [1:0]   w_gnt;
  logic [127:0] w_req_data;
  logic         w_rsp_rdy;
  logic         w_timeout;

  // The core's busy flag is informational only; nothing here depends on it.
  logic w_unused;
  assign w_unused = core_busy_i;

  // (base + off) mod N_REQ. base < N_REQ and off < N_REQ, so one subtraction
  // is always enough.
  function automatic logic [1:0] wrap_idx(input logic [1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return 2'(s);
  endfunction

  // Round-robin pick. Offsets are scanned from the highest down, so the
  // assignment made last comes from the nearest valid requester at or
  // after r_rr_ptr.
  // NOTE: every variable driven in an always_comb gets a default at the top.
  // Without it, a path that skips the assignment infers a latch.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (req_valid_i[j] && (wrap_idx(r_rr_ptr, k) == 2'(j))) begin
          w_found = 1'b1;
          w_gnt   = 2'(j);
        end
      end
    end
  end

  // Channel muxes. One selects the granted requester's block. The other
  // selects the owner's rsp_ready, so the other channels' ready bits are
  // ignored.
  always_comb begin
    w_req_data = '0;
    w_rsp_rdy  = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (w_gnt == 2'(j))   w_req_data = req_data_i[128*j +: 128];
      if (r_grant == 2'(j)) w_rsp_rdy  = rsp_ready_i[j];
    end
  end

  // Next-state logic. A core_valid_i arriving in the timeout cycle wins.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (core_valid_i) begin
          w_next = S_RESP;
        end else if (r_cnt == TIMEOUT_C) begin
          w_timeout = 1'b1;
          w_next    = S_ACK;
        end
      end
      S_RESP:  if (w_rsp_rdy) w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state. req_ready_o is also gated by rst_i.
  // The state is IDLE while reset is held, and the gate keeps the accept
  // strobe low even if a requester is valid during that time.
  always_comb begin
    for (int j = 0; j < N_REQ; j++) begin
      req_ready_o[j] = (r_state == S_IDLE) && !rst_i && w_found && (w_gnt == 2'(j));
      rsp_valid_o[j] = (r_state == S_RESP) && (r_grant == 2'(j));
      err_o[j]       = w_timeout && (r_grant == 2'(j));
    end
  end

  assign busy_o         = (r_state != S_IDLE);
  assign core_request_o = (r_state == S_ISSUE);
  assign core_ack_o     = (r_state == S_ACK);
  assign core_data_o    = r_core_data;
  assign rsp_data_o     = r_rsp_data;

  // NOTE: sequential state is written with <= only. The registers then all
  // sample pre-edge values, whatever order the statements appear in.
  // The 128-bit data registers are reset as well. After reset, the core and
  // the requesters must see zeros and not stale plaintext or ciphertext.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      r_core_data <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant     <= w_gnt;
            r_core_data <= w_req_data;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          if (core_valid_i) r_rsp_data <= core_data_i;
        end
        S_ACK:   r_rr_ptr <= wrap_idx(r_grant, 1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kuznechik_arbiter.sv
// Directed testbench for kuznechik_arbiter.
// u_dut uses TIMEOUT=255 and serves the normal-flow scenarios.
// u_dut_to uses TIMEOUT=10 and serves the timeout and race scenarios.
// Both instances share every input. Each scenario starts from a reset.
module tb_kuznechik_arbiter;

  localparam logic [127:0] PT = 128'h1122334455667700ffeeddccbbaa9988;
  localparam logic [127:0] CT = 128'h7f679d90bebc24305a468d42b9d4edcd;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [255:0] req_data;
  logic [1:0]   rsp_ready;
  logic         core_busy;
  logic         core_valid;
  logic [127:0] core_din;

  logic [1:0]   req_ready,   req_ready_b;
  logic [1:0]   rsp_valid,   rsp_valid_b;
  logic [127:0] rsp_data,    rsp_data_b;
  logic [1:0]   err,         err_b;
  logic         busy,        busy_b;
  logic         core_req,    core_req_b;
  logic [127:0] core_dout,   core_dout_b;
  logic         core_ack,    core_ack_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  kuznechik_arbiter #(.N_REQ(2), .TIMEOUT(255)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_ready_i(rsp_ready),
    .err_o(err), .busy_o(busy),
    .core_request_o(core_req), .core_data_o(core_dout), .core_ack_o(core_ack),
    .core_busy_i(core_busy), .core_valid_i(core_valid), .core_data_i(core_din)
  );

  kuznechik_arbiter #(.N_REQ(2), .TIMEOUT(10)) u_dut_to (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready_b),
    .rsp_valid_o(rsp_valid_b), .rsp_data_o(rsp_data_b), .rsp_ready_i(rsp_ready),
    .err_o(err_b), .busy_o(busy_b),
    .core_request_o(core_req_b), .core_data_o(core_dout_b), .core_ack_o(core_ack_b),
    .core_busy_i(core_busy), .core_valid_i(core_valid), .core_data_i(core_din)
  );

  // Inputs change on the falling edge. Outputs are sampled 1 ns later,
  // well clear of the rising edge. Every task returns on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; rsp_ready = '0; core_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete job on u_dut. Call it on a falling edge with the dut in IDLE
  // and req_valid already set. It returns on the falling edge of the IDLE
  // cycle after ACK.
  task automatic serve_job(input logic [1:0] exp_g, input logic [127:0] exp_in,
                           input logic [127:0] result, input int lat, input bit drop);
    logic [1:0] exp_rdy;
    int waited;
    exp_rdy = 2'b01 << exp_g;
    waited  = 0;
    #1;
    while (req_ready == 2'b00 && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL job_grant: req_ready=%b expected %b", req_ready, exp_rdy); end
    @(negedge clk);
    if (drop) req_valid = '0;
    #1;
    n_cmp++; if ({core_req, req_ready} !== 3'b100) begin n_bad++; $display("FAIL job_issue: core_req,req_ready=%b expected 100", {core_req, req_ready}); end
    n_cmp++; if (core_dout !== exp_in) begin n_bad++; $display("FAIL job_core_data: %h expected %h", core_dout, exp_in); end
    for (int i = 0; i < lat; i++) begin
      @(negedge clk); #1;
      n_cmp++; if ({core_req, rsp_valid, err, core_ack} !== 6'b0) begin n_bad++; $display("FAIL job_wait_quiet: outputs=%b expected 000000", {core_req, rsp_valid, err, core_ack}); end
    end
    core_valid = 1'b1; core_din = result;
    @(negedge clk);
    core_valid = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== exp_rdy) begin n_bad++; $display("FAIL job_rsp_valid: %b expected %b", rsp_valid, exp_rdy); end
    n_cmp++; if (rsp_data !== result) begin n_bad++; $display("FAIL job_rsp_data: %h expected %h", rsp_data, result); end
    n_cmp++; if (core_ack !== 1'b0) begin n_bad++; $display("FAIL job_ack_early: core_ack=%b expected 0", core_ack); end
    rsp_ready = exp_rdy;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    n_cmp++; if ({core_ack, rsp_valid} !== 3'b100) begin n_bad++; $display("FAIL job_ack: core_ack,rsp_valid=%b expected 100", {core_ack, rsp_valid}); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; req_data = {PT, PT}; rsp_ready = '0;
    core_busy = 1'b0; core_valid = 1'b0; core_din = CT;
    @(negedge clk); #1;
    n_cmp++; if ({req_ready, rsp_valid, err, busy, core_req, core_ack} !== 9'b0) begin n_bad++; $display("FAIL reset_ctrl: %b expected 0", {req_ready, rsp_valid, err, busy, core_req, core_ack}); end
    n_cmp++; if ({core_dout, rsp_data} !== 256'b0) begin n_bad++; $display("FAIL reset_data: core_data=%h rsp_data=%h expected 0", core_dout, rsp_data); end
    n_cmp++; if ({req_ready_b, busy_b, core_dout_b} !== 131'b0) begin n_bad++; $display("FAIL reset_b: ready=%b busy=%b data=%h expected 0", req_ready_b, busy_b, core_dout_b); end
    req_valid = '0;
  endtask

  task automatic test_single_job();
    do_reset();
    req_valid = 2'b01; req_data = {128'h0, PT};
    serve_job(2'd0, PT, CT, 40, 1'b1);
    #1;
    n_cmp++; if ({busy, core_ack, req_ready} !== 4'b0) begin n_bad++; $display("FAIL single_idle: busy,ack,ready=%b expected 0000", {busy, core_ack, req_ready}); end
  endtask

  task automatic test_contention();
    do_reset();
    req_valid = 2'b11; req_data = {128'hB1, 128'hA0};
    serve_job(2'd0, 128'hA0, 128'hC0, 3, 1'b0);
    serve_job(2'd1, 128'hB1, 128'hC1, 2, 1'b0);
    serve_job(2'd0, 128'hA0, 128'hC2, 5, 1'b0);
    serve_job(2'd1, 128'hB1, 128'hC3, 1, 1'b0);
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 2'b10; req_data = {128'hBEEF, 128'h5A5A};
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL bp_grant: %b expected 10", req_ready); end
    @(negedge clk);
    req_valid = 2'b01;
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL bp_ready_in_issue: %b expected 00", req_ready); end
    n_cmp++; if (core_dout !== 128'hBEEF) begin n_bad++; $display("FAIL bp_core_data: %h expected %h", core_dout, 128'hBEEF); end
    @(negedge clk);
    core_valid = 1'b1; core_din = 128'h1234;
    @(negedge clk);
    // Noise in RESP: a second core_valid and the other channel's ready.
    core_din = 128'hDEAD; rsp_ready = 2'b01;
    for (int i = 0; i < 20; i++) begin
      #1;
      n_cmp++; if ({rsp_valid, req_ready, core_ack} !== 5'b10000) begin n_bad++; $display("FAIL bp_hold: rsp_valid,req_ready,ack=%b expected 10000 cycle %0d", {rsp_valid, req_ready, core_ack}, i); end
      n_cmp++; if (rsp_data !== 128'h1234) begin n_bad++; $display("FAIL bp_data: %h expected %h cycle %0d", rsp_data, 128'h1234, i); end
      @(negedge clk);
    end
    core_valid = 1'b0; rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    n_cmp++; if ({core_ack, rsp_valid, req_ready} !== 5'b10000) begin n_bad++; $display("FAIL bp_ack: %b expected 10000", {core_ack, rsp_valid, req_ready}); end
    @(negedge clk); #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_next_grant: %b expected 01", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    logic [1:0] exp_err;
    do_reset();
    req_valid = 2'b01; req_data = {128'h0, PT};
    #1;
    n_cmp++; if (req_ready_b !== 2'b01) begin n_bad++; $display("FAIL to_grant: %b expected 01", req_ready_b); end
    @(negedge clk);
    req_valid = '0;
    #1;
    n_cmp++; if (core_req_b !== 1'b1) begin n_bad++; $display("FAIL to_request: %b expected 1", core_req_b); end
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk); #1;
      exp_err = (k == 11) ? 2'b01 : 2'b00;
      n_cmp++; if ({err_b, rsp_valid_b, core_ack_b} !== {exp_err, 3'b000}) begin n_bad++; $display("FAIL to_wait: err,rsp_valid,ack=%b expected %b at %0d", {err_b, rsp_valid_b, core_ack_b}, {exp_err, 3'b000}, k); end
    end
    @(negedge clk); #1;
    n_cmp++; if ({core_ack_b, err_b, rsp_valid_b} !== 5'b10000) begin n_bad++; $display("FAIL to_ack: %b expected 10000", {core_ack_b, err_b, rsp_valid_b}); end
    @(negedge clk); #1;
    n_cmp++; if ({busy_b, core_ack_b} !== 2'b00) begin n_bad++; $display("FAIL to_idle: busy,ack=%b expected 00", {busy_b, core_ack_b}); end
  endtask

  task automatic test_race();
    do_reset();
    req_valid = 2'b01; req_data = {128'h0, PT};
    @(negedge clk);
    req_valid = '0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    @(negedge clk);
    core_valid = 1'b1; core_din = CT;
    #1;
    n_cmp++; if (err_b !== 2'b00) begin n_bad++; $display("FAIL race_err: %b expected 00", err_b); end
    @(negedge clk);
    core_valid = 1'b0;
    #1;
    n_cmp++; if ({rsp_valid_b, err_b} !== 4'b0100) begin n_bad++; $display("FAIL race_rsp: rsp_valid,err=%b expected 0100", {rsp_valid_b, err_b}); end
    n_cmp++; if (rsp_data_b !== CT) begin n_bad++; $display("FAIL race_data: %h expected %h", rsp_data_b, CT); end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    n_cmp++; if (core_ack_b !== 1'b1) begin n_bad++; $display("FAIL race_ack: %b expected 1", core_ack_b); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    // The first job moves the round-robin pointer to 1.
    req_valid = 2'b01; req_data = {128'h77, 128'h66};
    serve_job(2'd0, 128'h66, 128'h99, 2, 1'b0);
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rw_grant: %b expected 01", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    n_cmp++; if (core_req !== 1'b1) begin n_bad++; $display("FAIL rw_request: %b expected 1", core_req); end
    repeat (5) @(negedge clk);
    rst = 1'b1; req_valid = 2'b11;
    #1;
    n_cmp++; if ({req_ready, rsp_valid, err, busy, core_req, core_ack} !== 9'b0) begin n_bad++; $display("FAIL rw_ctrl: %b expected 0", {req_ready, rsp_valid, err, busy, core_req, core_ack}); end
    n_cmp++; if ({core_dout, rsp_data} !== 256'b0) begin n_bad++; $display("FAIL rw_data: core_data=%h rsp_data=%h expected 0", core_dout, rsp_data); end
    @(negedge clk); #1;
    n_cmp++; if ({err, core_ack, req_ready} !== 5'b0) begin n_bad++; $display("FAIL rw_held: %b expected 0", {err, core_ack, req_ready}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rw_first_grant: %b expected 01", req_ready); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_contention();
    test_backpressure();
    test_timeout();
    test_race();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
